// File: rtl/packet_deser_pkg.sv
// Shared types and default sizing for the packet deserializer.
package packet_deser_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int END_LEN_DEF = 4;
    localparam int DEPTH_DEF   = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

endpackage

// File: rtl/packet_deser_pkt_fifo.sv
// Synchronous word FIFO with full/empty flags and same-cycle push/pop.
module pkt_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic          do_push_s;
    logic          do_pop_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;
    assign full      = (cnt_r == CNT_FULL);
    assign empty     = (cnt_r == {(AW+1){1'b0}});
    assign rdata     = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/packet_deser.sv
// Packet payload deserializer: strips the end marker, packs MSB-first words, queues them.
// Optional packet counter output enabled by macro PACKET_DESER_PKT_CNT_EN.
module packet_deser
    import packet_deser_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int END_LEN = END_LEN_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dataIn,
    input  logic              begP,
    input  logic              endP,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_align,
    output logic              err_ovf
`ifdef PACKET_DESER_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_count
`endif
);

    localparam int FW = $clog2(END_LEN + 1);
    localparam int BW = $clog2(DATA_W);
    localparam logic [FW-1:0] FILL_FULL = FW'(END_LEN);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    state_e              state_r, state_nx_s;
    logic                in_pkt_s, close_s, restart_s;
    logic [END_LEN-1:0]  pipe_r;
    logic [FW-1:0]       fill_r;
    logic [DATA_W-2:0]   asm_r;
    logic [BW-1:0]       bitcnt_r;
    logic [DATA_W-1:0]   stage_r;
    logic                stage_vld_r, flush_r;
    logic                pay_vld_s, pay_bit_s, word_done_s, partial_s;
    logic [DATA_W-1:0]   word_s;
    logic                push_s, push_last_s, pop_s, full_s, empty_s, drop_s;
    logic                err_align_r, err_ovf_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_nx_s;
    end

    // Next state: a coincident begP reopens the packet that endP just closed.
    always_comb begin
        state_nx_s = IDLE;
        case (state_r)
            IDLE:    state_nx_s = begP ? IN_PKT : IDLE;
            IN_PKT:  state_nx_s = (endP && !begP) ? IDLE : IN_PKT;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM decode of packet events.
    always_comb begin
        in_pkt_s  = 1'b0;
        close_s   = 1'b0;
        restart_s = 1'b0;
        case (state_r)
            IN_PKT: begin
                in_pkt_s  = 1'b1;
                close_s   = endP;
                restart_s = begP && !endP;
            end
            IDLE: begin
                in_pkt_s  = 1'b0;
                close_s   = 1'b0;
                restart_s = 1'b0;
            end
            default: begin
                in_pkt_s  = 1'b0;
                close_s   = 1'b0;
                restart_s = 1'b0;
            end
        endcase
    end

    // The bit leaving a full pipe is payload; the END_LEN bits still behind it may be the marker.
    assign pay_vld_s   = in_pkt_s && (fill_r == FILL_FULL);
    assign pay_bit_s   = pipe_r[END_LEN-1];
    assign word_s      = {asm_r, pay_bit_s};
    assign word_done_s = pay_vld_s && (bitcnt_r == BIT_LAST);
    assign partial_s   = close_s && (pay_vld_s ? !word_done_s : (bitcnt_r != {BW{1'b0}}));

    // Strip pipe and word assembler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_r   <= {END_LEN{1'b0}};
            fill_r   <= {FW{1'b0}};
            asm_r    <= {(DATA_W-1){1'b0}};
            bitcnt_r <= {BW{1'b0}};
        end else if (begP || close_s) begin
            pipe_r   <= {END_LEN{1'b0}};
            fill_r   <= {FW{1'b0}};
            asm_r    <= {(DATA_W-1){1'b0}};
            bitcnt_r <= {BW{1'b0}};
        end else if (in_pkt_s) begin
            pipe_r <= {pipe_r[END_LEN-2:0], dataIn};
            if (fill_r != FILL_FULL) fill_r <= fill_r + FW'(1);
            if (pay_vld_s) begin
                asm_r    <= word_s[DATA_W-2:0];
                bitcnt_r <= word_done_s ? {BW{1'b0}} : bitcnt_r + BW'(1);
            end
        end
    end

    // Staging: a word is only known to be non-final once its successor completes;
    // the final word is flushed the cycle after endP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r     <= {DATA_W{1'b0}};
            stage_vld_r <= 1'b0;
            flush_r     <= 1'b0;
        end else if (flush_r) begin
            stage_vld_r <= 1'b0;
            flush_r     <= 1'b0;
        end else if (restart_s) begin
            stage_vld_r <= 1'b0;
        end else if (word_done_s) begin
            stage_r     <= word_s;
            stage_vld_r <= 1'b1;
            flush_r     <= close_s;
        end else if (close_s) begin
            flush_r     <= 1'b1;
        end
    end

    // FIFO push selection.
    always_comb begin
        push_s      = 1'b0;
        push_last_s = 1'b0;
        if (flush_r && stage_vld_r) begin
            push_s      = 1'b1;
            push_last_s = 1'b1;
        end else if (word_done_s && stage_vld_r && !restart_s) begin
            push_s      = 1'b1;
            push_last_s = 1'b0;
        end else begin
            push_s      = 1'b0;
            push_last_s = 1'b0;
        end
    end

    assign pop_s  = !empty_s && out_ready;
    assign drop_s = push_s && full_s && !pop_s;

    pkt_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .wdata ({push_last_s, stage_r}),
        .pop   (pop_s),
        .rdata ({out_last, out_data}),
        .full  (full_s),
        .empty (empty_s)
    );

    assign out_valid = !empty_s;
    assign err_align = err_align_r;
    assign err_ovf   = err_ovf_r;

    // Error flags: alignment pulse, sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_align_r <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            err_align_r <= partial_s;
            err_ovf_r   <= err_ovf_r | drop_s;
        end
    end

`ifdef PACKET_DESER_PKT_CNT_EN
    logic [15:0] pkt_cnt_r;

    // Saturating count of packets whose last word entered the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_r <= 16'h0000;
        end else if (push_s && push_last_s && !drop_s && (pkt_cnt_r != 16'hFFFF)) begin
            pkt_cnt_r <= pkt_cnt_r + 16'h0001;
        end
    end

    assign pkt_count = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_packet_deser.sv
// Self-checking bench for packet_deser: directed and randomized packets against a word-queue model.
module tb_packet_deser;
    import packet_deser_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int EL = END_LEN_DEF;
    localparam int DP = DEPTH_DEF;

    logic          clk = 1'b0;
    logic          reset, dataIn, begP, endP, out_ready;
    logic [DW-1:0] out_data;
    logic          out_last, out_valid, err_align, err_ovf;
`ifdef PACKET_DESER_PKT_CNT_EN
    logic [15:0]   pkt_count;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];
    logic          pay_q[$];
    int            align_exp = 0;
    int            align_seen = 0;
    int            pkts_exp = 0;
    bit            ovf_exp = 1'b0;
    bit            rand_ready = 1'b0;
    bit            ready_hold = 1'b1;
    bit            hold_mode = 1'b0;
    bit            held = 1'b0;
    logic [DW:0]   held_q;

    packet_deser dut (
        .clk       (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .begP      (begP),
        .endP      (endP),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_align (err_align),
        .err_ovf   (err_ovf)
`ifdef PACKET_DESER_PKT_CNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One stimulus cycle, applied just after the rising edge.
    task automatic drive(input logic b, input logic bp, input logic ep);
        @(posedge clk);
        #1;
        dataIn    = b;
        begP      = bp;
        endP      = ep;
        out_ready = rand_ready ? rb() : ready_hold;
    endtask

    task automatic load_bits(input logic [63:0] v, input int n);
        pay_q.delete();
        for (int i = n - 1; i >= 0; i--) pay_q.push_back(v[i]);
    endtask

    task automatic rand_bits(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(rb());
    endtask

    task automatic model_push(input logic [DW:0] e, input bit is_last);
        if (hold_mode && exp_q.size() >= DP) begin
            ovf_exp = 1'b1;
        end else begin
            exp_q.push_back(e);
            if (is_last) pkts_exp++;
        end
    endtask

    // Expected words come from slicing the payload into whole DW-bit groups.
    task automatic send_pkt(input int pre, input bit skip_beg, input bit chain);
        int          n;
        int          words;
        bit          partial;
        logic [DW-1:0] w;
        n       = pay_q.size();
        words   = n / DW;
        partial = (n % DW) != 0;
        for (int i = 0; i < words; i++) begin
            for (int k = 0; k < DW; k++) w[DW-1-k] = pay_q[i*DW+k];
            model_push({(i == words - 1), w}, (i == words - 1));
        end
        if (partial) align_exp++;
        if (!skip_beg) drive(rb(), 1'b1, 1'b0);
        if (pre > 0) begin
            repeat (pre) drive(rb(), 1'b0, 1'b0);
            drive(rb(), 1'b1, 1'b0);
        end
        foreach (pay_q[i]) drive(pay_q[i], 1'b0, 1'b0);
        repeat (EL - 1) drive(rb(), 1'b0, 1'b0);
        drive(rb(), chain, 1'b1);
        if (!chain) begin
            drive(rb(), 1'b0, 1'b0);
            @(negedge clk);
            chk("err_align_after_endp", 32'(err_align), 32'(partial));
        end
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < max_cycles) begin
            drive(rb(), 1'b0, 1'b0);
            k++;
        end
        chk("drain_words_left", 32'(exp_q.size()), 32'(0));
        repeat (2) drive(rb(), 1'b0, 1'b0);
    endtask

    // Output monitor: scoreboard pops, hold stability, alignment pulse count.
    always @(negedge clk) begin
        if (!reset) begin
            held = 1'b0;
        end else begin
            if (err_align) align_seen++;
            if (held) chk("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, held_q}));
            held   = out_valid && !out_ready;
            held_q = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_word observed=%0h expected=none", {out_last, out_data});
                    end
                end else begin
                    chk("word", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b0; dataIn = 1'b0; begP = 1'b0; endP = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_align", 32'(err_align), 32'(0));
        chk("rst_ovf", 32'(err_ovf), 32'(0));
        reset = 1'b1;
        ready_hold = 1'b1;

        // Two aligned words.
        load_bits(64'hA53C, 16);
        send_pkt(0, 1'b0, 1'b0);
        drain(100);

        // One word plus a 4-bit partial.
        load_bits(64'hF0A, 12);
        send_pkt(0, 1'b0, 1'b0);
        drain(100);

        // Restart after 5 bits, then 0x81.
        load_bits(64'h81, 8);
        send_pkt(5, 1'b0, 1'b0);
        drain(100);

        // Empty packet and a 3-bit partial one.
        pay_q.delete();
        send_pkt(0, 1'b0, 1'b0);
        load_bits(64'h5, 3);
        send_pkt(0, 1'b0, 1'b0);

        // begP coinciding with endP chains two packets.
        load_bits(64'h5A, 8);
        send_pkt(0, 1'b0, 1'b1);
        load_bits(64'hC3E, 12);
        send_pkt(0, 1'b1, 1'b0);
        drain(100);
        chk("align_count_directed", 32'(align_seen), 32'(align_exp));

        // Overflow: five one-word packets with the consumer stalled.
        hold_mode = 1'b1; ready_hold = 1'b0;
        drive(rb(), 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            rand_bits(8);
            send_pkt(0, 1'b0, 1'b0);
        end
        repeat (3) drive(rb(), 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_sticky", 32'(err_ovf), 32'(ovf_exp));
        chk("ovf_valid", 32'(out_valid), 32'(1));
        hold_mode = 1'b0; ready_hold = 1'b1;
        drain(100);
        chk("ovf_still_set", 32'(err_ovf), 32'(1));

        // Reset mid-packet with two words queued.
        ready_hold = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rand_bits(8);
            send_pkt(0, 1'b0, 1'b0);
        end
        drive(rb(), 1'b1, 1'b0);
        repeat (6) drive(rb(), 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_ovf", 32'(err_ovf), 32'(0));
        chk("midrst_data", 32'(out_data), 32'(0));
        exp_q.delete();
        ovf_exp = 1'b0;
        pkts_exp = 0;
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        ready_hold = 1'b1;
        load_bits(64'h3C, 8);
        send_pkt(0, 1'b0, 1'b0);
        drain(100);

        // Packets with 2, 0 and 1 complete words.
        load_bits(64'h1234, 16);
        send_pkt(0, 1'b0, 1'b0);
        load_bits(64'h2, 2);
        send_pkt(0, 1'b0, 1'b0);
        load_bits(64'h7E, 8);
        send_pkt(0, 1'b0, 1'b0);
        drain(100);
`ifdef PACKET_DESER_PKT_CNT_EN
        chk("pkt_count", 32'(pkt_count), 32'(pkts_exp));
`endif

        // Randomized packets, restarts, chaining and consumer back-pressure.
        rand_ready = 1'b1;
        begin
            bit chain_prev;
            bit chain;
            int pre;
            chain_prev = 1'b0;
            for (int p = 0; p < 16; p++) begin
                rand_bits($urandom_range(0, 40));
                pre   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
                chain = (p < 15) && ($urandom_range(0, 3) == 0);
                send_pkt(pre, chain_prev, chain);
                chain_prev = chain;
                if (!chain) repeat ($urandom_range(0, 3)) drive(rb(), 1'b0, 1'b0);
            end
        end
        rand_ready = 1'b0;
        ready_hold = 1'b1;
        drain(200);
        chk("align_count_total", 32'(align_seen), 32'(align_exp));
        chk("ovf_final", 32'(err_ovf), 32'(ovf_exp));
`ifdef PACKET_DESER_PKT_CNT_EN
        chk("pkt_count_final", 32'(pkt_count), 32'(pkts_exp));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
